// File: rtl/alu_seq_psr.sv
// Sequential CR16-style ALU with valid/ready handshake, persistent CLFZN status register,
// one-bit-per-cycle shifts and a shift-add unsigned multiply.
module alu_seq_psr #(
  parameter int WIDTH  = 16,
  parameter int SHW    = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [4:0]       clfzn
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic [4:0]       psr_reg, psr_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             left_reg, left_next;
  logic             arith_reg, arith_next;

  // Decoded view of the incoming operation
  logic [WIDTH-1:0] dec_s;
  logic [4:0]       dec_flags, dec_mask;
  logic             dec_shift, dec_left, dec_arith, dec_mul;

  logic [WIDTH:0]   sum_ab, sum_abc, diff_ba;
  logic             ovf_ab, ovf_abc, ovf_sub;
  logic             accept;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_abc = sum_ab + {{WIDTH{1'b0}}, psr_reg[4]};
  assign diff_ba = {1'b0, b} - {1'b0, a};
  assign ovf_ab  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_abc = (a[WIDTH-1] == b[WIDTH-1]) && (sum_abc[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ba[WIDTH-1] == b[WIDTH-1]);

  always_comb begin
    dec_s     = '0;
    dec_flags = '0;
    dec_mask  = '0;
    dec_shift = 1'b0;
    dec_left  = 1'b0;
    dec_arith = 1'b0;
    dec_mul   = 1'b0;
    case (opcode)
      4'b0000: begin
        case (opext)
          4'b0001: dec_s = a & b;
          4'b0010: dec_s = a | b;
          4'b0011: dec_s = a ^ b;
          4'b0100: dec_s = ~a;
          4'b0101: begin
            dec_s = sum_ab[WIDTH-1:0];
            dec_flags = {sum_ab[WIDTH], 1'b0, ovf_ab, 2'b00};
            dec_mask  = 5'b10100;
          end
          4'b0110: begin
            dec_s = sum_ab[WIDTH-1:0];
            dec_flags = {sum_ab[WIDTH], 1'b0, sum_ab[WIDTH], 2'b00};
            dec_mask  = 5'b10100;
          end
          4'b0111, 4'b1100: begin
            dec_shift = 1'b1;
            dec_left  = 1'b1;
          end
          4'b1000: begin
            dec_shift = 1'b1;
            dec_arith = 1'b1;
          end
          4'b1001: begin
            dec_s = diff_ba[WIDTH-1:0];
            dec_flags = {diff_ba[WIDTH], 1'b0, ovf_sub, 2'b00};
            dec_mask  = 5'b10100;
          end
          4'b1010: begin
            dec_s = sum_abc[WIDTH-1:0];
            dec_flags = {sum_abc[WIDTH], 1'b0, ovf_abc, 2'b00};
            dec_mask  = 5'b10100;
          end
          4'b1011: dec_mul = (MUL_EN != 0);
          4'b1101: dec_s = a;
          4'b1110: dec_shift = 1'b1;
          default: ;
        endcase
      end
      4'b0011, 4'b1011: begin
        dec_flags = {1'b0, a > b, 1'b0, a == b, $signed(a) > $signed(b)};
        dec_mask  = 5'b01011;
      end
      4'b0101: begin
        dec_s = sum_ab[WIDTH-1:0];
        dec_flags = {sum_ab[WIDTH], 1'b0, ovf_ab, 2'b00};
        dec_mask  = 5'b10100;
      end
      4'b0110: begin
        dec_s = sum_ab[WIDTH-1:0];
        dec_flags = {sum_ab[WIDTH], 1'b0, sum_ab[WIDTH], 2'b00};
        dec_mask  = 5'b10100;
      end
      4'b0111: dec_s = {a[WIDTH-1:8], b[7:0]};
      4'b1000: dec_s = a;
      4'b1001: begin
        dec_s = diff_ba[WIDTH-1:0];
        dec_flags = {diff_ba[WIDTH], 1'b0, ovf_sub, 2'b00};
        dec_mask  = 5'b10100;
      end
      4'b1110: dec_shift = 1'b1;
      default: ;
    endcase
  end

  // One-bit shifter on the working register; left/arith were latched at accept
  logic [WIDTH-1:0] shl1, shr1, shift1;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shl1[gi] = 1'b0;
        assign shr1[gi] = lo_reg[gi+1];
      end else if (gi == WIDTH-1) begin : g_msb
        assign shl1[gi] = lo_reg[gi-1];
        assign shr1[gi] = arith_reg & lo_reg[gi];
      end else begin : g_mid
        assign shl1[gi] = lo_reg[gi-1];
        assign shr1[gi] = lo_reg[gi+1];
      end
    end
  endgenerate
  assign shift1 = left_reg ? shl1 : shr1;

  // Shift-add multiply: {hi,lo} starts as {0,B} and shifts right once per iteration
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  assign mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};

  assign accept = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    psr_next   = psr_reg;
    a_next     = a_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    cnt_next   = cnt_reg;
    left_next  = left_reg;
    arith_next = arith_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        lo_next  = shift1;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          s_next     = shift1;
        end
      end
      MUL: begin
        hi_next  = mul_sum[WIDTH:1];
        lo_next  = mul_lo;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          s_next     = mul_lo;
          psr_next   = {|mul_sum[WIDTH:1], psr_reg[3:0]};
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      a_next     = a;
      left_next  = dec_left;
      arith_next = dec_arith;
      if (dec_mul) begin
        state_next = MUL;
        hi_next    = '0;
        lo_next    = b;
        cnt_next   = CW'(WIDTH);
      end else if (dec_shift && (b[SHW-1:0] != '0)) begin
        state_next = SHIFT;
        lo_next    = a;
        cnt_next   = {1'b0, b[SHW-1:0]};
      end else if (dec_shift) begin
        state_next = DONE;
        s_next     = a;
      end else begin
        state_next = DONE;
        s_next     = dec_s;
        psr_next   = (psr_reg & ~dec_mask) | (dec_flags & dec_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      psr_reg   <= '0;
      a_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      left_reg  <= 1'b0;
      arith_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      psr_reg   <= psr_next;
      a_reg     <= a_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      cnt_reg   <= cnt_next;
      left_reg  <= left_next;
      arith_reg <= arith_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign s         = s_reg;
  assign clfzn     = psr_reg;

endmodule

// File: tb/tb_alu_seq_psr.sv
// Directed bench for alu_seq_psr: hand-computed results, flags and latencies.
module tb_alu_seq_psr;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  opext;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic [4:0]  clfzn;

  int passed = 0;
  int total  = 0;

  alu_seq_psr #(.WIDTH(16), .SHW(4), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .opext(opext), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .clfzn(clfzn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents one op at a negedge, then measures cycles until out_valid (1 = cycle after accept)
  task automatic run(input string tag, input logic [3:0] oc, input logic [3:0] ext,
                     input logic [15:0] av, input logic [15:0] bv, input int exp_lat,
                     input logic [15:0] exp_s, input logic [4:0] exp_psr);
    int   lat;
    logic rdy_seen;
    in_valid = 1'b1; opcode = oc; opext = ext; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy_seen = rdy_seen | in_ready;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".s"}, s, exp_s);
    chk({tag, ".psr"}, clfzn, exp_psr);
    if (exp_lat > 1) chk({tag, ".busy"}, rdy_seen, 1'b0);
    $display("op %s a=%h b=%h lat=%0d s=%h clfzn=%b", tag, av, bv, lat, s, clfzn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; opext = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.s", s, 16'h0000);
    chk("rst.psr", clfzn, 5'b00000);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);

    // Arithmetic and PSR carry chaining (clfzn = C L F Z N)
    run("add",   4'b0000, 4'b0101, 16'h7FFF, 16'h0001, 1, 16'h8000, 5'b00100);
    run("addc0", 4'b0000, 4'b1010, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 5'b00000);
    run("addu",  4'b0000, 4'b0110, 16'hFFFF, 16'h0002, 1, 16'h0001, 5'b10100);
    run("addc1", 4'b0000, 4'b1010, 16'h0001, 16'h0001, 1, 16'h0003, 5'b00000);
    run("addu2", 4'b0000, 4'b0110, 16'hFFFF, 16'h0002, 1, 16'h0001, 5'b10100);
    run("cmp",   4'b0011, 4'b0000, 16'h8000, 16'h0001, 1, 16'h0000, 5'b11100);
    run("and",   4'b0000, 4'b0001, 16'hF0F0, 16'hFF00, 1, 16'hF000, 5'b11100);

    // Shifts
    run("arsh",  4'b0000, 4'b1000, 16'h8010, 16'h0004, 5, 16'hF801, 5'b11100);
    run("lsh0",  4'b0000, 4'b1100, 16'h1234, 16'h0010, 1, 16'h1234, 5'b11100);
    run("rshi",  4'b1110, 4'b0000, 16'h00F0, 16'h0003, 4, 16'h001E, 5'b11100);

    // Multiply
    run("mul35", 4'b0000, 4'b1011, 16'h0003, 16'h0005, 17, 16'h000F, 5'b01100);
    run("mulhi", 4'b0000, 4'b1011, 16'h0100, 16'h0100, 17, 16'h0000, 5'b11100);

    // Backpressure then back-to-back accept
    in_valid = 1'b1; opcode = 4'b0000; opext = 4'b1101; a = 16'hABCD; b = 16'h0000;
    @(posedge clk); #1;
    out_ready = 1'b0;
    opext = 4'b0011; a = 16'h00FF; b = 16'h0F0F;
    @(negedge clk);
    chk("mov.s", s, 16'hABCD);
    chk("mov.out_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold.s", s, 16'hABCD);
      chk("hold.out_valid", out_valid, 1'b1);
      chk("hold.in_ready", in_ready, 1'b0);
      $display("hold cycle %0d s=%h out_valid=%b in_ready=%b", i, s, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.s", s, 16'h0FF0);
    chk("b2b.out_valid", out_valid, 1'b1);
    $display("b2b xor s=%h out_valid=%b", s, out_valid);

    // Reset in the middle of a multiply
    in_valid = 1'b1; opcode = 4'b0000; opext = 4'b1011; a = 16'h0003; b = 16'h0005;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mulrst.busy", out_valid, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mulrst.out_valid", out_valid, 1'b0);
    chk("mulrst.in_ready", in_ready, 1'b1);
    chk("mulrst.psr", clfzn, 5'b00000);
    chk("mulrst.s", s, 16'h0000);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("mulrst.no_result", seen, 1'b0);
    $display("mul reset abort out_valid_seen=%b clfzn=%b", seen, clfzn);

    // Subtract, NOP, MOVIU
    run("sub",   4'b0000, 4'b1001, 16'h0001, 16'h0003, 1, 16'h0002, 5'b00000);
    run("subi",  4'b1001, 4'b0000, 16'h0003, 16'h0001, 1, 16'hFFFE, 5'b10000);
    run("nop",   4'b0001, 4'b0000, 16'h1234, 16'h5678, 1, 16'h0000, 5'b10000);
    run("moviu", 4'b0111, 4'b0000, 16'h1234, 16'h00AB, 1, 16'h12AB, 5'b10000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_psr.md
Name: alu_seq_psr

Overview:
- Parametrised, clocked successor to the team's combinational CR16-style ALU.
- Keeps the {opcode, opext} encoding and the CLFZN flag layout.
- Adds:
  - a valid/ready handshake;
  - a registered result;
  - a persistent 5-bit processor status register (PSR) that feeds carry into ADDC;
  - multi-bit iterative shifts;
  - an iterative unsigned multiply.
- Sits in the execute stage between the register-file read and the writeback mux.

Parameters:
- WIDTH, 16, datapath width in bits; must be at least 9 (MOVIU uses the low 8 bits).
- SHW, 4, shift-amount width; must equal clog2(WIDTH).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL decodes as NOP.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  primary opcode.
- opext  in  4  extended opcode (ignored for immediate forms).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, immediate, or shift amount.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  registered result.
- clfzn  out  5  PSR contents: [4]C carry, [3]L unsigned-greater, [2]F overflow, [1]Z equal, [0]N signed-greater.

Behaviour:
- Reset values: state IDLE, s=0, clfzn=0, out_valid=0, in_ready=1.
  - Reset asserted mid-operation aborts it, discards the partial result and clears the PSR.
- Accept: an operation is accepted on a rising edge with in_valid && in_ready. Operands and op are latched at that edge.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - MUL: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - Single-cycle op: IDLE→DONE.
  - Shift: IDLE→SHIFT when amount≠0, otherwise →DONE.
  - MUL: IDLE→MUL.
  - SHIFT→DONE when the remaining count reaches 0.
  - MUL→DONE after WIDTH iterations.
  - DONE→IDLE on out_ready without a new accept.
  - DONE with out_ready && in_valid accepts the next op back-to-back.
- Latency from the accept edge to out_valid:
  - 1 cycle for single-cycle ops and shift-by-0.
  - 1+n cycles for shift-by-n (one bit per cycle).
  - WIDTH+1 cycles for MUL.
- s, out_valid and PSR update on the same edge.
  - s and out_valid hold while out_valid && !out_ready.
  - Ops with no flag mask leave the PSR unchanged.
- Ops (S=result; mod-2^WIDTH arithmetic):
  - ADD 0000_0101 / ADDI 0101_xxxx: S=A+B; C=carry out; F=signed overflow. Writes C,F.
  - ADDU 0000_0110 / ADDUI 0110_xxxx: S=A+B; C=carry out; F=C. Writes C,F.
  - ADDC 0000_1010: S=A+B+PSR.C; C and F as ADD. Writes C,F.
  - SUB 0000_1001 / SUBI 1001_xxxx: S=B−A; C=borrow (A>B unsigned); F=set when A and B differ in sign and S's sign equals B's sign. Writes C,F.
  - CMP 0011_xxxx / CMPI 1011_xxxx: S=0; L=A>B unsigned; Z=A==B; N=signed A > signed B. Writes L,Z,N; C and F hold.
  - Logical ops, no flags written: AND 0000_0001, OR 0000_0010, XOR 0000_0011, NOT 0000_0100 (bitwise ~A).
  - Moves, no flags written: MOV 0000_1101 and MOVI 1000_xxxx (S=A); MOVIU 0111_xxxx (S={A[WIDTH-1:8], B[7:0]}).
  - Shifts by n=B[SHW-1:0], no flags written:
    - LSH 0000_1100 and ALSH 0000_0111: zero fill, shift left.
    - RSH 0000_1110 and RSHI 1110_xxxx: zero fill, shift right.
    - ARSH 0000_1000: sign fill, shift right.
    - Upper bits of B are ignored.
  - MUL 0000_1011: shift-add, unsigned; S=low WIDTH bits of A*B; C=1 if the high half is nonzero. Writes C.
  - Any other encoding: NOP, S=0, no flags written, 1 cycle.
- in_valid while busy is not accepted. Upstream holds its inputs until in_ready.

Test Plan:
- Reset with no op: s=0, clfzn=0, out_valid=0, in_ready=1. Assert reset during MUL cycle 5 → IDLE next cycle, PSR=0, no out_valid.
- ADD a=0x7FFF, b=0x0001 → after 1 cycle s=0x8000, C=0, F=1. Then ADDC a=0xFFFF, b=0x0000 with C=0 → s=0xFFFF, C=0. ADDU 0xFFFF+0x0002 → s=0x0001, C=1, F=1. Then ADDC a=0x0001, b=0x0001 → s=0x0003.
- CMP a=0x8000, b=0x0001 → s=0, L=1, Z=0, N=0, C/F unchanged. Follow with AND → PSR unchanged.
- ARSH a=0x8010, b=0x0004 → out_valid exactly 5 cycles after accept, s=0xF801, in_ready=0 throughout. Shift with b=0 → 1 cycle, s=a.
- MUL 0x0100×0x0100 → 17 cycles, s=0x0000, C=1. MUL 0x0003×0x0005 → s=0x000F, C=0.
- Hold out_ready=0 for 3 cycles after a result: s and out_valid stable. Then out_ready=1 with in_valid=1 → next op accepted on the same edge (back-to-back).
